// File: rtl/disp_demux.sv
// -----------------------------------------------------------------------------
// disp_demux
//   Receive side of a 4-digit multiplexed 7-segment bus (sseg/an). The scanned
//   anode/segment stream is registered once and deglitched. Each stable
//   pattern is then classified as a digit capture, blanking or an illegal
//   anode pattern. The block rebuilds the four per-digit segment bytes and
//   reports frame completion, illegal anode patterns and a stalled scan.
//
// Parameters
//   SETTLE     consecutive identical samples of {an,sseg} needed to accept (2..15)
//   TIMEOUT_W  watchdog width; stale after 2^TIMEOUT_W-1 cycles without capture
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-low
//   sseg        in   8  segment bus, active-low {dp,g..a}
//   an          in   4  anode bus, active-low one-hot (E=digit0 .. 7=digit3)
//   out0..out3  out  8  last accepted segment byte per digit
//   valid       out  4  bit i set once digit i has been captured since reset
//   frame_done  out  1  pulse when digits 0..3 all captured in the current frame
//   an_err      out  1  pulse when a stable illegal anode pattern is accepted
//   stale       out  1  level, no capture within the watchdog window
// -----------------------------------------------------------------------------
module disp_demux #(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sseg,
  input  logic [3:0] an,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       an_err,
  output logic       stale
);

  localparam logic [3:0]           SETTLE_C  = 4'(SETTLE);
  localparam logic [3:0]           SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX    = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] WD_ONE    = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when exactly one anode line is driven low.
  function automatic logic is_onehot_low(input logic [3:0] a);
    logic r;
    case (a)
      4'hE, 4'hD, 4'hB, 4'h7: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Digit index of a one-hot-low anode pattern (0 for anything else).
  function automatic logic [1:0] digit_idx(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'hE:    r = 2'd0;
      4'hD:    r = 2'd1;
      4'hB:    r = 2'd2;
      4'h7:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [3:0]           an_q, an_p;
  logic [7:0]           sseg_q, sseg_p;
  logic [3:0]           cnt;
  logic [3:0]           seen;
  logic [TIMEOUT_W-1:0] wd;
  state_t               state;

  logic                 same_s;
  logic                 accept_s;
  logic                 cap_s;
  logic                 err_s;
  logic [1:0]           idx_s;
  logic [3:0]           bit_s;
  logic [TIMEOUT_W-1:0] wd_next_s;

  // Accept decode, classification and next watchdog value.
  always_comb begin
    same_s    = ({an_q, sseg_q} == {an_p, sseg_p});
    // Accept only on the cnt SETTLE-1 -> SETTLE transition, once per stable period.
    accept_s  = same_s && (cnt == SETTLE_M1);
    cap_s     = accept_s && is_onehot_low(an_q);
    err_s     = accept_s && !is_onehot_low(an_q) && (an_q != 4'hF);
    idx_s     = digit_idx(an_q);
    bit_s     = 4'b0001 << idx_s;
    if (cap_s) begin
      wd_next_s = '0;
    end else if (wd == WD_MAX) begin
      wd_next_s = wd;
    end else begin
      wd_next_s = wd + WD_ONE;
    end
  end

  // Input sampling, previous-sample register and stability counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_q   <= 4'hF;
      sseg_q <= 8'hFF;
      an_p   <= 4'hF;
      sseg_p <= 8'hFF;
      cnt    <= 4'd0;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      an_p   <= an_q;
      sseg_p <= sseg_q;
      if (!same_s) begin
        cnt <= 4'd1;
      end else if (cnt < SETTLE_C) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Per-digit capture registers, valid mask and illegal-pattern pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out0   <= 8'hFF;
      out1   <= 8'hFF;
      out2   <= 8'hFF;
      out3   <= 8'hFF;
      valid  <= 4'b0000;
      an_err <= 1'b0;
    end else begin
      an_err <= err_s;
      if (cap_s) begin
        valid <= valid | bit_s;
        case (idx_s)
          2'd0:    out0 <= sseg_q;
          2'd1:    out1 <= sseg_q;
          2'd2:    out2 <= sseg_q;
          2'd3:    out3 <= sseg_q;
          default: out0 <= out0;
        endcase
      end
    end
  end

  // Watchdog counter and registered stale level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd    <= '0;
      stale <= 1'b0;
    end else begin
      wd    <= wd_next_s;
      stale <= (wd_next_s == WD_MAX);
    end
  end

  // Frame tracking FSM: SYNC waits for a digit0 capture, RUN collects digits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SYNC;
      seen       <= 4'b0000;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SYNC: begin
          if (cap_s && (idx_s == 2'd0)) begin
            seen  <= 4'b0001;
            state <= RUN;
          end else begin
            seen  <= seen;
            state <= SYNC;
          end
        end
        RUN: begin
          if (err_s) begin
            seen  <= 4'b0000;
            state <= SYNC;
          end else if (cap_s) begin
            if ((seen & bit_s) != 4'b0000) begin
              // Repeated digit: restart the frame from this digit. Only a
              // repeated digit0 is a valid frame start, others resynchronise.
              seen  <= bit_s;
              state <= (idx_s == 2'd0) ? RUN : SYNC;
            end else if ((seen | bit_s) == 4'hF) begin
              frame_done <= 1'b1;
              seen       <= 4'b0000;
              state      <= RUN;
            end else begin
              seen  <= seen | bit_s;
              state <= RUN;
            end
          end else begin
            seen  <= seen;
            state <= RUN;
          end
        end
        default: begin
          seen  <= 4'b0000;
          state <= SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_demux.sv
// -----------------------------------------------------------------------------
// tb_disp_demux
//   Directed self-checking bench for disp_demux (SETTLE=4, TIMEOUT_W=6).
//   Inputs are driven 1 time unit after the rising edge, and outputs are
//   sampled at that same point.
// -----------------------------------------------------------------------------
module tb_disp_demux;

  logic       clk;
  logic       rst;
  logic [7:0] sseg;
  logic [3:0] an;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       frame_done;
  logic       an_err;
  logic       stale;

  int checks;
  int errors;
  int fd_cnt;
  int err_cnt;
  int both_cnt;

  disp_demux #(
    .SETTLE   (4),
    .TIMEOUT_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sseg      (sseg),
    .an        (an),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .valid     (valid),
    .frame_done(frame_done),
    .an_err    (an_err),
    .stale     (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a pattern for n cycles, counting output pulses along the way.
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
      if (an_err === 1'b1) err_cnt++;
      if (frame_done === 1'b1 && an_err === 1'b1) both_cnt++;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fd_cnt   = 0;
    err_cnt  = 0;
    both_cnt = 0;
    rst  = 1'b0;
    an   = 4'hF;
    sseg = 8'hFF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_out0", 32'(out0), 32'h0000_00FF);
    check("rst_out1", 32'(out1), 32'h0000_00FF);
    check("rst_out2", 32'(out2), 32'h0000_00FF);
    check("rst_out3", 32'(out3), 32'h0000_00FF);
    check("rst_valid", 32'(valid), 32'h0000_0000);
    check("rst_stale", 32'(stale), 32'h0000_0000);
    check("rst_fd", 32'(frame_done), 32'h0000_0000);
    check("rst_err", 32'(an_err), 32'h0000_0000);
    rst = 1'b1;

    // First scan with capture latency check on digit0 (SETTLE+1 edges)
    hold(4'hE, 8'h01, 4);
    check("lat_out0_early", 32'(out0), 32'h0000_00FF);
    check("lat_valid_early", 32'(valid), 32'h0000_0000);
    hold(4'hE, 8'h01, 1);
    check("lat_out0", 32'(out0), 32'h0000_0001);
    check("lat_valid", 32'(valid), 32'h0000_0001);
    hold(4'hE, 8'h01, 3);
    hold(4'hD, 8'h02, 8);
    hold(4'hB, 8'h03, 8);
    check("scan_fd_before_d3", 32'(fd_cnt), 32'd0);
    hold(4'h7, 8'h04, 8);
    check("scan_out0", 32'(out0), 32'h0000_0001);
    check("scan_out1", 32'(out1), 32'h0000_0002);
    check("scan_out2", 32'(out2), 32'h0000_0003);
    check("scan_out3", 32'(out3), 32'h0000_0004);
    check("scan_valid", 32'(valid), 32'h0000_000F);
    check("scan_fd", 32'(fd_cnt), 32'd1);

    // Glitch on digit0: 00 shows for only 2 cycles and must not be captured
    hold(4'hE, 8'h1B, 2);
    hold(4'hE, 8'h00, 2);
    check("glitch_no_cap", 32'(out0), 32'h0000_0001);
    hold(4'hE, 8'h1B, 8);
    check("glitch_out0", 32'(out0), 32'h0000_001B);
    check("glitch_fd", 32'(fd_cnt), 32'd1);

    // Illegal anode pattern: single an_err pulse at SETTLE+1
    hold(4'hC, 8'h1B, 4);
    check("err_early", 32'(an_err), 32'h0000_0000);
    hold(4'hC, 8'h1B, 1);
    check("err_pulse", 32'(an_err), 32'h0000_0001);
    hold(4'hC, 8'h1B, 1);
    check("err_single", 32'(an_err), 32'h0000_0000);
    check("err_count", 32'(err_cnt), 32'd1);
    check("err_out0", 32'(out0), 32'h0000_001B);
    check("err_out1", 32'(out1), 32'h0000_0002);
    check("err_out3", 32'(out3), 32'h0000_0004);
    check("err_valid", 32'(valid), 32'h0000_000F);

    // FSM back in SYNC: D,B do not count, E,D,B,7 completes one frame
    hold(4'hD, 8'h11, 8);
    hold(4'hB, 8'h12, 8);
    hold(4'hE, 8'h20, 8);
    hold(4'hD, 8'h21, 8);
    hold(4'hB, 8'h22, 8);
    check("resync_no_fd", 32'(fd_cnt), 32'd1);
    hold(4'h7, 8'h23, 8);
    check("resync_fd", 32'(fd_cnt), 32'd2);
    check("resync_out0", 32'(out0), 32'h0000_0020);
    check("resync_out1", 32'(out1), 32'h0000_0021);
    check("resync_out2", 32'(out2), 32'h0000_0022);
    check("resync_out3", 32'(out3), 32'h0000_0023);

    // Watchdog: last capture was 3 edges before this hold, so stale rises
    // after 60 blanked cycles (wd reaches 63).
    hold(4'hF, 8'hFF, 59);
    check("stale_early", 32'(stale), 32'h0000_0000);
    hold(4'hF, 8'hFF, 1);
    check("stale_set", 32'(stale), 32'h0000_0001);
    hold(4'hF, 8'hFF, 10);
    check("stale_hold", 32'(stale), 32'h0000_0001);
    check("stale_no_err", 32'(err_cnt), 32'd1);
    hold(4'hD, 8'h55, 4);
    check("stale_before_cap", 32'(stale), 32'h0000_0001);
    hold(4'hD, 8'h55, 1);
    check("stale_cleared", 32'(stale), 32'h0000_0000);
    check("stale_out1", 32'(out1), 32'h0000_0055);
    hold(4'hD, 8'h55, 3);

    // Repeated digit0 restarts the frame: seen {1,0} -> E again -> {0}
    hold(4'hE, 8'h30, 8);
    hold(4'hF, 8'hFF, 8);
    hold(4'hE, 8'h31, 8);
    hold(4'hB, 8'h32, 8);
    hold(4'h7, 8'h33, 8);
    check("repeat_no_fd", 32'(fd_cnt), 32'd2);
    hold(4'hD, 8'h34, 8);
    check("repeat_fd", 32'(fd_cnt), 32'd3);
    check("repeat_out0", 32'(out0), 32'h0000_0031);

    check("no_simultaneous", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
